dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_arbiter_if.sv | 40 ++++
 rtl/rr_arbiter2.sv | 29 ++
 rtl/dmem_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_arbiter.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// load/store mask codes, requester identifiers and access-check helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [3:0] MASK_BYTE  = 4'b0000;
    localparam logic [3:0] MASK_HALF  = 4'b0001;
    localparam logic [3:0] MASK_WORD  = 4'b0010;
    localparam logic [3:0] MASK_BYTEU = 4'b0100;
    localparam logic [3:0] MASK_HALFU = 4'b0101;

    // Requester identifiers; also the value held in the last-grant flop.
    localparam logic SRC_CORE = 1'b0;
    localparam logic SRC_DMA  = 1'b1;

    function automatic logic mask_legal(input logic [3:0] mask);
        return (mask == MASK_BYTE)  || (mask == MASK_HALF) ||
               (mask == MASK_WORD)  || (mask == MASK_BYTEU) ||
               (mask == MASK_HALFU);
    endfunction

    // Half accesses need addr[0]==0, word accesses need addr[1:0]==0.
    function automatic logic misaligned(input logic [3:0] mask, input logic [1:0] lsb);
        logic bad;
        bad = 1'b0;
        if ((mask == MASK_HALF) || (mask == MASK_HALFU)) bad = lsb[0];
        else if (mask == MASK_WORD)                      bad = |lsb;
        return bad;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: core requester, DMA requester and
// the single memory port. The arbiter uses the slave view; the environment
// (requesters plus memory) uses the master view.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          c_req, c_we, c_gnt, c_rvalid, c_err;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic [3:0]    c_mask;

    logic          d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [3:0]    d_mask;

    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [3:0]    m_mask;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_mask,
        output c_gnt, c_rvalid, c_err, c_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_mask,
        output d_gnt, d_rvalid, d_err, d_rdata,
        output m_we, m_addr, m_wdata, m_mask,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_mask,
        input  c_gnt, c_rvalid, c_err, c_rdata,
        output d_req, d_we, d_addr, d_wdata, d_mask,
        input  d_gnt, d_rvalid, d_err, d_rdata,
        input  m_we, m_addr, m_wdata, m_mask,
        output m_rdata
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. A lone requester always wins; on contention
// the requester not granted last wins. Reset leaves DMA as last winner so
// the core takes the first contended grant.
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,   // [0] core, [1] DMA
    input  logic       en_i,    // grant is taken this cycle
    output logic [1:0] gnt_o
);
    logic last_q, last_d;

    // Winner selection and last-grant update.
    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (req_i[0] && (!req_i[1] || (last_q == SRC_DMA))) gnt_o[0] = 1'b1;
        else if (req_i[1])                                  gnt_o[1] = 1'b1;
        if (en_i && (|gnt_o)) last_d = gnt_o[1];
    end

    // Last-grant flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= SRC_DMA;
        else        last_q <= last_d;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one memory port between the core and a DMA
// requester. One transaction in flight: grant (IDLE) -> memory access
// (ACCESS) -> response (RESP). Illegal masks never write and answer err=1.
// Optional build macro DMEM_ARB_MISALIGN_EN: also reject misaligned half and
// word accesses with err=1 and no write.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    state_e        state_q, state_d;
    logic          src_q, we_q, err_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, rdata_q;
    logic [3:0]    mask_q;

    logic [1:0]    arb_gnt;
    logic          in_idle, in_access, in_resp, take;
    logic          sel_we, sel_err;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [3:0]    sel_mask;

    assign in_idle   = (state_q == ST_IDLE);
    assign in_access = (state_q == ST_ACCESS);
    assign in_resp   = (state_q == ST_RESP);
    assign take      = in_idle && (|arb_gnt);

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({bus.d_req, bus.c_req}),
        .en_i  (in_idle),
        .gnt_o (arb_gnt)
    );

    assign sel_we    = arb_gnt[1] ? bus.d_we    : bus.c_we;
    assign sel_addr  = arb_gnt[1] ? bus.d_addr  : bus.c_addr;
    assign sel_wdata = arb_gnt[1] ? bus.d_wdata : bus.c_wdata;
    assign sel_mask  = arb_gnt[1] ? bus.d_mask  : bus.c_mask;

`ifdef DMEM_ARB_MISALIGN_EN
    assign sel_err = !mask_legal(sel_mask) || misaligned(sel_mask, sel_addr[1:0]);
`else
    assign sel_err = !mask_legal(sel_mask);
`endif

    // Next-state logic: a grant starts the fixed three-step sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (|arb_gnt) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Request latch at grant, read-data capture at the end of ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= SRC_CORE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (take) begin
                src_q   <= arb_gnt[1];
                we_q    <= sel_we;
                err_q   <= sel_err;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                mask_q  <= sel_mask;
            end
            if (in_access) rdata_q <= (we_q || err_q) ? '0 : bus.m_rdata;
        end
    end

    // Grants are gated by rst_n so nothing is acknowledged while in reset.
    assign bus.c_gnt    = rst_n && in_idle && arb_gnt[0];
    assign bus.d_gnt    = rst_n && in_idle && arb_gnt[1];

    assign bus.m_we     = in_access && we_q && !err_q;
    assign bus.m_addr   = in_access ? addr_q  : '0;
    assign bus.m_wdata  = in_access ? wdata_q : '0;
    assign bus.m_mask   = in_access ? mask_q  : '0;

    assign bus.c_rvalid = in_resp && (src_q == SRC_CORE);
    assign bus.d_rvalid = in_resp && (src_q == SRC_DMA);
    assign bus.c_err    = bus.c_rvalid && err_q;
    assign bus.d_err    = bus.d_rvalid && err_q;
    assign bus.c_rdata  = bus.c_rvalid ? rdata_q : '0;
    assign bus.d_rdata  = bus.d_rvalid ? rdata_q : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a word-addressed memory model.
module tb_dmem_arbiter;
    logic clk;
    logic rst_n;
    logic init_done;
    logic [31:0] mem [0:63];
    int n_chk;
    int n_pass;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on rising edge.
    assign bus.m_rdata = mem[bus.m_addr[7:2]];
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[8] <= 32'h1111_1111;
        end else if (bus.m_we) begin
            mem[bus.m_addr[7:2]] <= bus.m_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0; bus.c_mask = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_mask = 0;
    endtask

    // Single-requester transaction starting from IDLE; checks grant,
    // memory access and response cycle by cycle.
    task automatic txn(input string tag, input bit dma, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input logic [31:0] exp_rd,
                       input bit exp_err, input bit exp_mwe);
        @(negedge clk);
        if (dma) begin
            bus.d_req = 1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_mask = mask;
        end else begin
            bus.c_req = 1; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata; bus.c_mask = mask;
        end
        #1;
        chk({tag, ".gnt"}, 32'(dma ? bus.d_gnt : bus.c_gnt), 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk({tag, ".m_we"}, 32'(bus.m_we), 32'(exp_mwe));
        chk({tag, ".m_addr"}, bus.m_addr, addr);
        chk({tag, ".gnt_busy"}, 32'(bus.c_gnt | bus.d_gnt), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, ".rvalid"}, 32'(dma ? bus.d_rvalid : bus.c_rvalid), 32'd1);
        chk({tag, ".other_rvalid"}, 32'(dma ? bus.c_rvalid : bus.d_rvalid), 32'd0);
        chk({tag, ".rdata"}, dma ? bus.d_rdata : bus.c_rdata, exp_rd);
        chk({tag, ".err"}, 32'(dma ? bus.d_err : bus.c_err), 32'(exp_err));
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        init_done = 0;
        idle_inputs();
        rst_n = 0;
        bus.c_req = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.c_gnt", 32'(bus.c_gnt), 32'd0);
        chk("rst.m_we", 32'(bus.m_we), 32'd0);
        chk("rst.m_addr", bus.m_addr, 32'd0);
        chk("rst.rvalid", 32'(bus.c_rvalid | bus.d_rvalid), 32'd0);
        chk("rst.rdata", bus.c_rdata | bus.d_rdata, 32'd0);
        bus.c_req = 0;
        init_done = 1;
        @(negedge clk);
        rst_n = 1;

        // Core word write, then DMA read of the same word.
        txn("cwr", 0, 1, 32'h10, 32'hDEAD_BEEF, 4'b0010, 32'h0, 0, 1);
        txn("drd", 1, 0, 32'h10, 32'h0, 4'b0010, 32'hDEAD_BEEF, 0, 0);

        // Both requesters held through four transactions: strict alternation.
        @(negedge clk);
        bus.c_req = 1; bus.c_addr = 32'h10; bus.c_mask = 4'b0010;
        bus.d_req = 1; bus.d_addr = 32'h10; bus.d_mask = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d.c_gnt", k), 32'(bus.c_gnt), 32'((k % 2) == 0));
            chk($sformatf("rr%0d.d_gnt", k), 32'(bus.d_gnt), 32'((k % 2) == 1));
            @(negedge clk);
            if (k == 3) idle_inputs();
            #1;
            chk($sformatf("rr%0d.busy_gnt", k), 32'(bus.c_gnt | bus.d_gnt), 32'd0);
            @(negedge clk);
            #1;
            chk($sformatf("rr%0d.c_rvalid", k), 32'(bus.c_rvalid), 32'((k % 2) == 0));
            chk($sformatf("rr%0d.rdata", k), bus.c_rdata | bus.d_rdata, 32'hDEAD_BEEF);
            @(negedge clk);
        end

        // Illegal mask: no write, err with zero data.
        txn("ill", 0, 1, 32'h20, 32'h1234_5678, 4'b0111, 32'h0, 1, 0);
        @(negedge clk);
        chk("ill.mem", mem[8], 32'h1111_1111);

        // Misaligned word write to 0x22.
`ifdef DMEM_ARB_MISALIGN_EN
        txn("mis", 0, 1, 32'h22, 32'hCAFE_F00D, 4'b0010, 32'h0, 1, 0);
        @(negedge clk);
        chk("mis.mem", mem[8], 32'h1111_1111);
`else
        txn("mis", 0, 1, 32'h22, 32'hCAFE_F00D, 4'b0010, 32'h0, 0, 1);
        @(negedge clk);
        chk("mis.mem", mem[8], 32'hCAFE_F00D);
`endif

        // Reset pulsed during ACCESS of a core write.
        bus.c_req = 1; bus.c_we = 1; bus.c_addr = 32'h30; bus.c_wdata = 32'h55AA_55AA; bus.c_mask = 4'b0010;
        #1;
        chk("rmid.gnt", 32'(bus.c_gnt), 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("rmid.m_we_pre", 32'(bus.m_we), 32'd1);
        rst_n = 0;
        #1;
        chk("rmid.m_we", 32'(bus.m_we), 32'd0);
        chk("rmid.m_addr", bus.m_addr, 32'd0);
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rmid.rvalid%0d", k), 32'(bus.c_rvalid | bus.d_rvalid), 32'd0);
        end
        chk("rmid.mem", mem[12], 32'h0);
        @(negedge clk);
        bus.c_req = 1; bus.c_addr = 32'h10; bus.c_mask = 4'b0010;
        bus.d_req = 1; bus.d_addr = 32'h10; bus.d_mask = 4'b0010;
        #1;
        chk("rmid.c_wins", 32'(bus.c_gnt), 32'd1);
        chk("rmid.d_loses", 32'(bus.d_gnt), 32'd0);
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
